// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one combinational-read word memory between fetch (I) and load/store (D) requesters
module mem_port_arbiter #(
  parameter int WORDS = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
  localparam logic [31:0] WLIM = WORDS;
  logic [SW-1:0] streak;
  logic i_ok, d_ok, i_forced;
  always_comb begin
    i_ok = i_addr[1:0] == 2'b00 && {2'b00, i_addr[31:2]} < WLIM;
    d_ok = d_addr[1:0] == 2'b00 && {2'b00, d_addr[31:2]} < WLIM;
    i_forced = streak == SMAX;
    i_gnt = !rst && i_req && (!d_req || i_forced);
    d_gnt = !rst && d_req && !(i_req && i_forced);
    mem_address = i_gnt ? i_addr : d_gnt ? d_addr : '0;
    mem_write_data = d_wdata;
    mem_write_enable = d_gnt && d_we && d_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
      i_rvalid <= 1'b0;
      i_rdata <= '0;
      i_err <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata <= '0;
      d_err <= 1'b0;
    end else begin
      streak <= (!i_req || i_gnt) ? '0 : (d_gnt && !i_forced) ? streak + 1'b1 : streak;
      i_rvalid <= i_gnt;
      i_err <= i_gnt && !i_ok;
      d_rvalid <= d_gnt;
      d_err <= d_gnt && !d_ok;
      if (i_gnt) i_rdata <= i_ok ? mem_read_data : '0;
      if (d_gnt) d_rdata <= (!d_we && d_ok) ? mem_read_data : '0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus random traffic against a queue-based scoreboard and word-array reference
module tb_mem_port_arbiter;
  localparam int WORDS = 64;
  localparam int MAXS = 4;
  typedef struct {logic [31:0] data; logic err;} rsp_t;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_write_enable;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem [WORDS];
  logic [31:0] rmem [WORDS];
  rsp_t iq[$], dq[$];
  int checks = 0, failures = 0, streak_m = 0;
  logic i_done = 0, d_done = 0;
  logic [9:0] gnt_log = 0;
  logic [31:0] last_i = 0, last_d = 0;

  mem_port_arbiter #(.WORDS(WORDS), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic ok_addr(input logic [31:0] a);
    return a % 4 == 0 && a / 4 < WORDS;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(9);
    if (r == 0) return 4 * $urandom_range(WORDS - 1) + $urandom_range(3, 1);
    if (r == 1) return 4 * (WORDS + $urandom_range(1000));
    return 4 * $urandom_range(WORDS - 1);
  endfunction

  // Grant checker: predicts arbitration and memory-side lines, queues the expected response
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_i_gnt", i_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_we", mem_write_enable, 0);
      streak_m = 0;
      i_done = 0;
      d_done = 0;
    end else begin
      logic ei, ed, dok;
      logic [31:0] ea;
      ei = i_req && (!d_req || streak_m == MAXS);
      ed = d_req && !ei;
      dok = ok_addr(d_addr);
      ea = ei ? i_addr : ed ? d_addr : 0;
      chk("i_gnt", i_gnt, ei);
      chk("d_gnt", d_gnt, ed);
      chk("mem_address", mem_address, ea);
      chk("mem_we", mem_write_enable, ed && d_we && dok);
      if (ed && d_we) chk("mem_wdata", mem_write_data, d_wdata);
      if (i_gnt || d_gnt) gnt_log = {gnt_log[8:0], i_gnt};
      if (ei) iq.push_back('{ok_addr(i_addr) ? rmem[i_addr[7:2]] : 0, !ok_addr(i_addr)});
      if (ed) begin
        dq.push_back('{(!d_we && dok) ? rmem[d_addr[7:2]] : 0, !dok});
        if (d_we && dok) rmem[d_addr[7:2]] = d_wdata;
      end
      streak_m = (!i_req || ei) ? 0 : (ed && streak_m < MAXS) ? streak_m + 1 : streak_m;
      i_done = ei;
      d_done = ed;
    end
  end

  // Response monitor: every queued response must appear exactly one cycle after its grant
  always @(posedge clk) begin
    logic r;
    rsp_t e;
    r = rst;
    #2;
    if (r) begin
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_err", i_err, 0);
      chk("rst_d_err", d_err, 0);
      last_i = 0;
      last_d = 0;
    end else begin
      chk("i_rvalid", i_rvalid, iq.size() > 0);
      if (iq.size() > 0) begin
        e = iq.pop_front();
        if (i_rvalid) begin
          chk("i_rdata", i_rdata, e.data);
          chk("i_err", i_err, e.err);
          last_i = e.data;
        end
      end else begin
        chk("i_err_idle", i_err, 0);
        chk("i_rdata_hold", i_rdata, last_i);
      end
      chk("d_rvalid", d_rvalid, dq.size() > 0);
      if (dq.size() > 0) begin
        e = dq.pop_front();
        if (d_rvalid) begin
          chk("d_rdata", d_rdata, e.data);
          chk("d_err", d_err, e.err);
          last_d = e.data;
        end
      end else begin
        chk("d_err_idle", d_err, 0);
        chk("d_rdata_hold", d_rdata, last_d);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    i_req = 0;
    d_req = 0;
    d_we = 0;
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) begin
      logic [31:0] v;
      v = $urandom;
      mem[k] = v;
      rmem[k] = v;
    end
    mem[2] = 32'hDEADBEEF;
    rmem[2] = 32'hDEADBEEF;
    i_req = 1;
    d_req = 1;
    i_addr = 32'h10;
    d_addr = 32'h14;
    d_we = 1;
    d_wdata = 32'hA5A5A5A5;
    step(3);
    rst = 0;
    idle();
    step(2);
    i_req = 1;
    i_addr = 32'h08;
    step();
    idle();
    step();
    d_req = 1;
    d_we = 1;
    d_addr = 32'h0C;
    d_wdata = 32'h12345678;
    step();
    d_we = 0;
    step();
    idle();
    step(2);
    gnt_log = 0;
    i_req = 1;
    d_req = 1;
    i_addr = 32'h20;
    d_addr = 32'h24;
    step(10);
    idle();
    chk("grant_order", {22'b0, gnt_log}, 32'b0000100001);
    step(2);
    d_req = 1;
    d_we = 1;
    d_addr = 32'h06;
    d_wdata = 32'hCAFEF00D;
    step();
    d_addr = 32'h100;
    step();
    d_we = 0;
    d_addr = 32'h04;
    step();
    d_addr = 32'h00;
    step();
    idle();
    step(2);
    d_req = 1;
    d_we = 1;
    d_addr = 32'h30;
    d_wdata = 32'hBAD0BAD0;
    rst = 1;
    step();
    rst = 0;
    idle();
    step();
    d_req = 1;
    d_addr = 32'h30;
    step();
    idle();
    step(2);
    for (int c = 0; c < 400; c++) begin
      if (!i_req || i_done) begin
        i_req = $urandom_range(2) != 0;
        i_addr = rand_addr();
      end else if ($urandom_range(15) == 0) i_req = 0;
      if (!d_req || d_done) begin
        d_req = $urandom_range(3) != 0;
        d_we = $urandom_range(1);
        d_addr = rand_addr();
        d_wdata = $urandom;
      end else if ($urandom_range(15) == 0) d_req = 0;
      step();
    end
    idle();
    step(3);
    chk("i_queue_drained", iq.size(), 0);
    chk("d_queue_drained", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
